// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and sizing for the instruction-fetch queue.
//   fetch_entry_t : one buffered instruction together with the PC it was fetched from
//   FQ_DATA_W     : instruction / PC width used by fetch_entry_t
//   FQ_DEPTH      : default queue depth
//   FQ_CNT_W      : width of a counter that must hold 0..FQ_DEPTH inclusive
package fetch_pkg;

    localparam int unsigned FQ_DATA_W = 16;
    localparam int unsigned FQ_DEPTH  = 4;
    localparam int unsigned FQ_CNT_W  = $clog2(FQ_DEPTH + 1);

    typedef struct packed {
        logic [FQ_DATA_W-1:0] pc;
        logic [FQ_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// DEPTH-entry synchronous FIFO of fetch_entry_t with a synchronous flush.
// The head entry is read combinationally from registered storage, so a pushed
// entry becomes visible one cycle after it is written.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush_i        : empty the FIFO at the next edge (a concurrent pop is harmless)
//   push_i         : write push_entry_i
//   pop_i          : discard the head entry
//   head_o         : head entry (zero after reset)
//   head_valid_o   : FIFO holds at least one entry
//   count_o        : number of stored entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned CNT_W = FQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic             head_valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    assign head_o       = mem_q[rd_ptr_q];
    assign head_valid_o = (count_q != '0);
    assign count_o      = count_q;

    // Storage is reset so the head reads as zero straight out of reset.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch stage with a prefetch queue. Issues in-order requests to
// instruction memory ahead of decode, buffers the returned words with their PCs,
// and hands them to ID over a valid/ready handshake. A redirect flushes the queue
// and marks every still-outstanding request as stale so its response is dropped.
// DATA_W must match fetch_pkg::FQ_DATA_W, the width carried by fetch_entry_t.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   fetch_en                       : allow new requests (outstanding ones still complete)
//   redirect_valid, redirect_pc    : one-cycle redirect strobe and target
//   imem_req_valid/ready/addr      : request channel to instruction memory
//   imem_rsp_valid/data            : in-order response channel, no backpressure
//   out_valid/ready, out_pc/instr  : head instruction towards ID
//   occupancy                      : entries currently held in the queue
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       DATA_W   = FQ_DATA_W,
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DEPTH    = FQ_DEPTH,
    parameter int unsigned       PC_STEP  = 2,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [DATA_W-1:0]          redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [ADDR_W-1:0]          imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [DATA_W-1:0]          imem_rsp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] fpc_q, fpc_d;
    logic [DATA_W-1:0] rpc_q, rpc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W:0]    credit_used;
    logic              req_fire;
    logic              rsp_keep;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Credit covers stored entries plus outstanding responses, so every accepted
    // request is guaranteed a queue slot. Gating with rst_n keeps the request
    // low while reset is held even though the request is combinational.
    assign credit_used    = {1'b0, occupancy} + {1'b0, inflight_q};
    assign imem_req_valid = rst_n && fetch_en && !redirect_valid
                            && (credit_used < (CNT_W + 1)'(DEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = fpc_q[ADDR_W-1:0];

    // A response is queued only if it is not stale and no redirect is flushing.
    assign rsp_keep   = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign pop        = out_valid && out_ready;
    assign push_entry = '{pc: rpc_q, instr: imem_rsp_data};

    // Next-state for the PCs and counters. On a redirect every outstanding
    // request except one answered in this very cycle becomes stale; no request
    // can fire in that cycle, so the new drop count equals the new inflight count.
    always_comb begin
        fpc_d      = fpc_q;
        rpc_d      = rpc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        if (redirect_valid) begin
            fpc_d  = redirect_pc;
            rpc_d  = redirect_pc;
            drop_d = inflight_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fpc_d = fpc_q + DATA_W'(PC_STEP);
            end
            if (rsp_keep) begin
                rpc_d = rpc_q + DATA_W'(PC_STEP);
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            rpc_q      <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fpc_q      <= fpc_d;
            rpc_q      <= rpc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .push_i       (rsp_keep),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .head_valid_o (out_valid),
        .count_o      (occupancy)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Random and directed stimulus for fetch_queue_unit. The memory model tags each
// accepted request with the redirect epoch it was issued in; a response whose
// epoch is still current produces the next expected {pc, instr} on the
// scoreboard. The monitor checks every handshake against the scoreboard head.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] pc;
        logic [11:0] addr;
        int          epoch;
        int          due;
    } memReq_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } expEntry_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [11:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [2:0]  occupancy;

    memReq_t     memQ[$];
    expEntry_t   sbQ[$];
    memReq_t     curRsp;
    bit          rspActive;
    int          testsRun;
    int          testsFailed;
    int          cyc;
    int          epoch;
    int          lastDue;
    int          sbSizeCycle;
    logic [15:0] nextReqPc;

    int          lat;
    int          readyPct;
    int          reqReadyPct;
    int          fenPct;
    int          redirPct;
    bit          forceRedirect;
    logic [15:0] forceRedirPc;

    fetch_queue_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .occupancy      (occupancy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: a scrambled function of the word address.
    function automatic logic [15:0] memWord(input logic [11:0] a);
        logic [15:0] wide;
        wide = {4'h0, a};
        return 16'(wide * 16'd40503) ^ 16'h5A3C;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then advance n cycles.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            rspActive = 1'b0;
            if (memQ.size() > 0 && memQ[0].due <= cyc) begin
                curRsp    = memQ.pop_front();
                rspActive = 1'b1;
            end
            imem_rsp_valid = rspActive;
            imem_rsp_data  = rspActive ? memWord(curRsp.addr) : 16'($urandom);
            imem_req_ready = ($urandom_range(0, 99) < reqReadyPct);
            out_ready      = ($urandom_range(0, 99) < readyPct);
            fetch_en       = ($urandom_range(0, 99) < fenPct);
            if (forceRedirect) begin
                redirect_valid = 1'b1;
                redirect_pc    = forceRedirPc;
                forceRedirect  = 1'b0;
            end else begin
                redirect_valid = ($urandom_range(0, 99) < redirPct);
                redirect_pc    = 16'($urandom) & 16'hFFFE;
            end
        end
    endtask

    // Monitor: queue size and head validity must track the scoreboard; every
    // handshake must deliver the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            sbSizeCycle = sbQ.size();
            checkOutput("occupancy", 32'(occupancy), 32'(sbQ.size()));
            checkOutput("out_valid", 32'(out_valid), 32'(sbQ.size() != 0));
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL pop_underflow: got pc 0x%0h, expected no entry (cycle %0d)",
                             out_pc, cyc);
                end else begin
                    expEntry_t e;
                    e = sbQ.pop_front();
                    checkOutput("out_pc", 32'(out_pc), 32'(e.pc));
                    checkOutput("out_instr", 32'(out_instr), 32'(e.instr));
                end
            end
        end
    end

    // Reference bookkeeping for the cycle just observed: request credit, request
    // addresses, memory acceptance, response fate and redirect flushes.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            int inflightModel;
            bit expReqValid;
            inflightModel = memQ.size() + (rspActive ? 1 : 0);
            expReqValid   = fetch_en && !redirect_valid
                            && (sbSizeCycle + inflightModel < DEPTH);
            checkOutput("req_valid", 32'(imem_req_valid), 32'(expReqValid));
            if (rspActive && !redirect_valid && curRsp.epoch == epoch) begin
                sbQ.push_back('{pc: curRsp.pc, instr: memWord(curRsp.pc[11:0])});
            end
            if (imem_req_valid && imem_req_ready) begin
                memReq_t r;
                checkOutput("req_addr", 32'(imem_req_addr), 32'(nextReqPc[11:0]));
                r.pc    = nextReqPc;
                r.addr  = imem_req_addr;
                r.epoch = epoch;
                r.due   = (cyc + lat > lastDue + 1) ? cyc + lat : lastDue + 1;
                lastDue = r.due;
                memQ.push_back(r);
                nextReqPc = nextReqPc + 16'd2;
            end
            if (redirect_valid) begin
                epoch++;
                nextReqPc = redirect_pc;
                sbQ.delete();
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        checkOutput({tag, "_occupancy"}, 32'(occupancy), 32'd0);
        checkOutput({tag, "_req_addr"}, 32'(imem_req_addr), 32'd0);
        checkOutput({tag, "_out_pc"}, 32'(out_pc), 32'd0);
        checkOutput({tag, "_out_instr"}, 32'(out_instr), 32'd0);
    endtask

    task automatic clearModel();
        memQ.delete();
        sbQ.delete();
        rspActive      = 1'b0;
        imem_rsp_valid = 1'b0;
        nextReqPc      = 16'h0000;
        lastDue        = 0;
        epoch++;
    endtask

    initial begin
        testsRun       = 0;
        testsFailed    = 0;
        cyc            = 0;
        epoch          = 0;
        lastDue        = 0;
        sbSizeCycle    = 0;
        nextReqPc      = 16'h0000;
        rspActive      = 1'b0;
        forceRedirect  = 1'b0;
        forceRedirPc   = 16'h0000;
        lat            = 1;
        readyPct       = 100;
        reqReadyPct    = 100;
        fenPct         = 100;
        redirPct       = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        out_ready      = 1'b1;

        // Reset values while reset is held with fetch_en high.
        #1;
        checkResetValues("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Steady stream with single-cycle memory.
        applyStimulus(30);

        // Stall: queue fills to DEPTH, then resumes.
        readyPct = 0;
        applyStimulus(12);
        checkOutput("stall_occupancy", 32'(occupancy), 32'(DEPTH));
        readyPct = 100;
        applyStimulus(20);

        // Redirect while a response and a pop land in the same cycle.
        forceRedirect = 1'b1;
        forceRedirPc  = 16'h0200;
        applyStimulus(20);

        // Redirect with three requests outstanding at latency 3.
        lat = 3;
        applyStimulus(15);
        forceRedirect = 1'b1;
        forceRedirPc  = 16'h0100;
        applyStimulus(20);

        // fetch_en low mid-stream, then restored.
        fenPct = 0;
        applyStimulus(10);
        fenPct = 100;
        applyStimulus(15);

        // Randomised traffic with varying latency.
        readyPct    = 70;
        reqReadyPct = 75;
        fenPct      = 90;
        redirPct    = 3;
        for (int i = 0; i < 12; i++) begin
            lat = $urandom_range(1, 4);
            applyStimulus(100);
        end

        // Asynchronous reset pulsed between edges mid-stream.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        clearModel();
        redirPct = 0;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(20);

        // More random traffic after the restart.
        redirPct = 3;
        for (int i = 0; i < 5; i++) begin
            lat = $urandom_range(1, 4);
            applyStimulus(100);
        end

        // Drain: no new requests, ID always ready.
        redirPct = 0;
        fenPct   = 0;
        readyPct = 100;
        applyStimulus(20);
        #4;
        checkOutput("drain_occupancy", 32'(occupancy), 32'd0);
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch stage with a prefetch queue, successor to the single-cycle IF stage. It keeps a fetch PC, issues in-order requests to instruction memory ahead of decode, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to ID over a valid/ready handshake. Branch and jump redirects from MEM flush the queue and discard stale in-flight responses.

## Interface
- DATA_W, 16: instruction and PC width
- ADDR_W, 12: instruction address bus width; the address is the low ADDR_W bits of the PC
- DEPTH, 4: queue entries, a power of two, at least 2; also the maximum number of in-flight requests
- PC_STEP, 2: PC increment per instruction
- RESET_PC, 0: fetch PC after reset

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  allows new requests; when low, in-flight responses still complete
- redirect_valid  in  1  PCSrc-equivalent: one-cycle redirect strobe
- redirect_pc  in  DATA_W  target PC
- imem_req_valid  out  1  request issue
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  ADDR_W  fetch address
- imem_rsp_valid  in  1  response; in order, no backpressure, at least 1 cycle after acceptance
- imem_rsp_data  in  DATA_W  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  ID accepts; low means stall
- out_pc  out  DATA_W  PC of the head instruction
- out_instr  out  DATA_W  head instruction
- occupancy  out  $clog2(DEPTH+1)  valid entries in the queue

## Operation
- State:
  - fpc: next PC to request
  - rpc: PC of the next non-stale response
  - inflight: requests accepted with no response yet, range 0..DEPTH
  - drop: stale in-flight requests, always at most inflight
  - the queue
- Request condition: imem_req_valid = fetch_en && !redirect_valid && (occupancy + inflight < DEPTH). This depends combinationally on redirect_valid.
- Request acceptance (valid && ready):
  - fpc += PC_STEP, modulo 2^DATA_W
  - inflight += 1
- Response handling:
  - every response: inflight -= 1
  - if drop > 0: drop -= 1 and the data is discarded
  - otherwise: push {rpc, data} into the queue, then rpc += PC_STEP
- Pop on out_valid && out_ready. Push and pop in the same cycle are allowed at any occupancy, including full.
- Redirect in cycle t:
  - fpc and rpc are set to redirect_pc
  - the queue is emptied; a pop in cycle t still completes, but nothing is pushed
  - drop = inflight − (imem_rsp_valid ? 1 : 0), counted after any response in cycle t, which is itself discarded
  - no request is issued in cycle t
- A redirect while drop > 0 recomputes drop with the same rule.
- Queue overflow is impossible: credit counts in-flight responses as well as stored entries.
- Counter wrap: fpc and rpc wrap naturally. inflight and drop are sized $clog2(DEPTH+1) and never exceed DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release):
  - fpc = rpc = RESET_PC
  - inflight = drop = 0, queue empty
  - out_valid = 0, imem_req_valid = 0, occupancy = 0
  - imem_req_addr = RESET_PC[ADDR_W-1:0]
  - out_pc = out_instr = 0
- First request: the first clk edge after release with fetch_en high.
- Response to out_valid latency: 1 cycle (the entry is registered, with no bypass).
- Redirect in cycle t:
  - out_valid = 0 from cycle t+1
  - first request to redirect_pc in cycle t+1
- Throughput: one instruction per cycle once memory latency is at most DEPTH−1 cycles.
- Reset asserted mid-operation: all state is cleared immediately. Responses arriving after release are a system error and are not handled.

## Structure
- Package fetch_pkg:
  - typedef fetch_entry_t {pc, instr}, parameterised by DATA_W through the package parameter
  - localparam for the counter width
- One sub-module, fetch_fifo:
  - DEPTH-entry synchronous FIFO of fetch_entry_t, with a synchronous flush and an occupancy output
  - head read combinationally from the registered storage
- The top level holds the PC registers, the inflight/drop counters and the credit logic.

## Test plan
- Steady stream: memory with latency 1, out_ready held high → out_pc = 0, 2, 4, … on consecutive cycles, with instructions matching the memory image.
- Stall: out_ready low for 10 cycles → occupancy reaches 4, no 5th request is issued, and the stream resumes in order with no gaps or duplicates.
- Redirect with 3 in flight: redirect_pc = 0x0100 with memory latency 3 → the 3 old responses are dropped, and the first output is pc 0x0100 with the word at 0x100.
- Simultaneous events: redirect, a response, and a pop in the same cycle → the popped entry is delivered once, the response is discarded, and drop equals inflight−1.
- fetch_en low mid-stream: in-flight responses are still queued, no new requests are issued, and requests resume at the correct fpc when fetch_en returns high.
- Async reset mid-stream: rst_n pulsed low between edges → outputs immediately match the reset values, and fetching restarts at RESET_PC.
